// File: rtl/UART_host_pkg.sv
// Shared types for the UART host packet block.
// State encoding, header field layout and serial bit timing.
package UART_host_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    DATA,
    CKSUM
  } state_t;

  localparam int HDR_STALE_BIT = 7;
  localparam int HDR_LEN_LSB   = 0;
  localparam int HDR_LEN_W     = 4;

  localparam int BAUD_CYC = 16;

endpackage

// File: rtl/UART_rx.sv
// 8N1 serial receiver sampling mid-bit.
// rdy holds until clr_rdy; a new byte wins over a clear.
module UART_rx
  import UART_host_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy
);

  localparam logic [7:0] BAUD_M1 = 8'(BAUD_CYC - 1);
  localparam logic [7:0] HALF    = 8'(BAUD_CYC / 2);

  logic       r_s1, r_s2;
  logic       r_busy;
  logic [7:0] r_cnt;
  logic [3:0] r_bit;
  logic [7:0] r_shift;
  logic [7:0] r_data;
  logic       r_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1    <= 1'b1;
      r_s2    <= 1'b1;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_rdy   <= 1'b0;
    end else begin
      r_s1 <= RX;
      r_s2 <= r_s1;
      if (clr_rdy) r_rdy <= 1'b0;
      if (!r_busy) begin
        if (!r_s2) begin
          r_busy <= 1'b1;
          r_cnt  <= HALF;
          r_bit  <= '0;
        end
      end else if (r_cnt != 8'd0) begin
        r_cnt <= r_cnt - 8'd1;
      end else begin
        r_cnt <= BAUD_M1;
        if (r_bit == 4'd9) begin
          r_busy <= 1'b0;
          r_data <= r_shift;
          r_rdy  <= 1'b1;
        end else begin
          if (r_bit != 4'd0) r_shift <= {r_s2, r_shift[7:1]};
          r_bit <= r_bit + 4'd1;
        end
      end
    end
  end

  assign rx_data = r_data;
  assign rdy     = r_rdy;

endmodule

// File: rtl/UART_tx.sv
// 8N1 serial transmitter, LSB first.
// tx_done pulses for one cycle at the end of the stop bit.
module UART_tx
  import UART_host_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       tx_done
);

  localparam logic [7:0] BAUD_M1 = 8'(BAUD_CYC - 1);

  logic [9:0] r_shift;
  logic [7:0] r_cnt;
  logic [3:0] r_bit;
  logic       r_busy;
  logic       r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '1;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (!r_busy) begin
        if (trmt) begin
          r_shift <= {1'b1, tx_data, 1'b0};
          r_busy  <= 1'b1;
          r_cnt   <= BAUD_M1;
          r_bit   <= '0;
        end
      end else if (r_cnt != 8'd0) begin
        r_cnt <= r_cnt - 8'd1;
      end else if (r_bit == 4'd9) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end else begin
        r_shift <= {1'b1, r_shift[9:1]};
        r_bit   <= r_bit + 4'd1;
        r_cnt   <= BAUD_M1;
      end
    end
  end

  assign TX      = r_shift[0];
  assign tx_done = r_done;

endmodule

// File: rtl/uart_host_pkt.sv
// Sends a shadowed controller packet over UART when the host asks.
// Optional header/checksum framing and stale-data timeout.
module uart_host_pkt
  import UART_host_pkg::*;
#(
  parameter int         NUM_BYTES   = 4,
  parameter logic [7:0] REQ_BYTE    = 8'hC6,
  parameter bit         HDR_EN      = 1'b0,
  parameter bit         CKSUM_EN    = 1'b0,
  parameter int         TIMEOUT_CYC = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [8*NUM_BYTES-1:0] cntlr_data,
  input  logic                   set_cntlr_data_rdy,
  input  logic                   RX,
  output logic                   TX,
  output logic                   busy,
  output logic                   pkt_sent,
  output logic [7:0]             stale_cnt
);

  localparam int          W    = 8 * NUM_BYTES;
  localparam logic [3:0]  NB4  = 4'(NUM_BYTES);
  localparam logic [3:0]  LAST = 4'(NUM_BYTES - 1);
  localparam logic [15:0] TMO  = 16'(TIMEOUT_CYC);

  state_t      r_state;
  logic [3:0]  r_idx;
  logic [15:0] r_tmo;
  logic        r_req;
  logic        r_fresh;
  logic [W-1:0] r_shadow;
  logic [W-1:0] r_send;
  logic        r_trmt;
  logic [7:0]  r_tx_byte;
  logic        r_pkt_sent;
  logic [7:0]  r_stale_cnt;

  logic        w_rx_rdy;
  logic [7:0]  w_rx_data;
  logic        w_tx_done;
  logic        w_req_hit;
  logic        w_expired;
  logic        w_start;
  logic [7:0]  w_hdr;
  logic [7:0]  w_first;
  logic [7:0]  w_next;
  logic [7:0]  w_cksum;

  UART_rx u_rx (
    .clk     (clk),
    .rst_n   (rst_n),
    .RX      (RX),
    .clr_rdy (w_rx_rdy),
    .rx_data (w_rx_data),
    .rdy     (w_rx_rdy)
  );

  UART_tx u_tx (
    .clk     (clk),
    .rst_n   (rst_n),
    .trmt    (r_trmt),
    .tx_data (r_tx_byte),
    .TX      (TX),
    .tx_done (w_tx_done)
  );

  assign w_req_hit = w_rx_rdy && (w_rx_data == REQ_BYTE);
  assign w_expired = (TMO != 16'd0) && (r_tmo == TMO);
  assign w_start   = (r_state == IDLE) && r_req
                   && (r_fresh || w_expired);

  always_comb begin
    w_hdr = '0;
    w_hdr[HDR_STALE_BIT] = !r_fresh;
    w_hdr[HDR_LEN_LSB +: HDR_LEN_W] = NB4;
  end

  assign w_first = HDR_EN ? w_hdr : r_shadow[7:0];

  always_comb begin
    w_next  = '0;
    w_cksum = '0;
    for (int k = 0; k < NUM_BYTES; k++) begin
      if (4'(k) == r_idx + 4'd1) w_next = r_send[8*k +: 8];
      w_cksum = w_cksum ^ r_send[8*k +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_tmo       <= '0;
      r_req       <= 1'b0;
      r_fresh     <= 1'b0;
      r_shadow    <= '0;
      r_send      <= '0;
      r_trmt      <= 1'b0;
      r_tx_byte   <= '0;
      r_pkt_sent  <= 1'b0;
      r_stale_cnt <= '0;
    end else begin
      r_trmt     <= 1'b0;
      r_pkt_sent <= 1'b0;
      if (w_start) r_tmo <= '0;
      else if ((TMO != 16'd0) && (r_state == IDLE) && r_req
               && !r_fresh && !w_expired)
        r_tmo <= r_tmo + 16'd1;
      unique case (r_state)
        IDLE: if (w_start) begin
          r_send    <= r_shadow;
          r_req     <= 1'b0;
          r_fresh   <= 1'b0;
          r_trmt    <= 1'b1;
          r_tx_byte <= w_first;
          r_idx     <= '0;
          if (!r_fresh && r_stale_cnt != 8'hFF)
            r_stale_cnt <= r_stale_cnt + 8'd1;
          r_state <= HDR_EN ? HDR : DATA;
        end
        HDR: if (w_tx_done) begin
          r_trmt    <= 1'b1;
          r_tx_byte <= r_send[7:0];
          r_idx     <= '0;
          r_state   <= DATA;
        end
        DATA: if (w_tx_done) begin
          if (r_idx != LAST) begin
            r_trmt    <= 1'b1;
            r_tx_byte <= w_next;
            r_idx     <= r_idx + 4'd1;
          end else if (CKSUM_EN) begin
            r_trmt    <= 1'b1;
            r_tx_byte <= w_cksum;
            r_state   <= CKSUM;
          end else begin
            r_pkt_sent <= 1'b1;
            r_state    <= IDLE;
          end
        end
        CKSUM: if (w_tx_done) begin
          r_pkt_sent <= 1'b1;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
      // a new request or data pulse in the start cycle survives the clear
      if (w_req_hit) r_req <= 1'b1;
      if (set_cntlr_data_rdy) begin
        r_shadow <= cntlr_data;
        r_fresh  <= 1'b1;
      end
    end
  end

  assign busy      = (r_state != IDLE);
  assign pkt_sent  = r_pkt_sent;
  assign stale_cnt = r_stale_cnt;

endmodule

// File: tb/tb_uart_host_pkt.sv
// Randomized bench for uart_host_pkt: three parameter sets,
// serial host stimulus and a packet-level reference model.
module tb_uart_host_pkt;
  import UART_host_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rx = '1;
  logic [2:0]  tx, busy, pkt;
  logic [2:0]  set = '0;
  logic [31:0] da = '0, dc = '0;
  logic [15:0] db = '0;
  logic [7:0]  sa, sb, sc;

  int n_chk = 0;
  int n_err = 0;
  logic [7:0] cap [3][64];
  int ncap [3];
  int npkt [3];
  logic [7:0] expq [$];

  uart_host_pkt u_a (
    .clk(clk), .rst_n(rst_n), .cntlr_data(da),
    .set_cntlr_data_rdy(set[0]), .RX(rx[0]), .TX(tx[0]),
    .busy(busy[0]), .pkt_sent(pkt[0]), .stale_cnt(sa));

  uart_host_pkt #(
    .NUM_BYTES(2), .HDR_EN(1'b1), .CKSUM_EN(1'b1)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .cntlr_data(db),
    .set_cntlr_data_rdy(set[1]), .RX(rx[1]), .TX(tx[1]),
    .busy(busy[1]), .pkt_sent(pkt[1]), .stale_cnt(sb));

  uart_host_pkt #(
    .HDR_EN(1'b1), .TIMEOUT_CYC(100)
  ) u_c (
    .clk(clk), .rst_n(rst_n), .cntlr_data(dc),
    .set_cntlr_data_rdy(set[2]), .RX(rx[2]), .TX(tx[2]),
    .busy(busy[2]), .pkt_sent(pkt[2]), .stale_cnt(sc));

  always @(negedge clk)
    for (int i = 0; i < 3; i++)
      if (pkt[i]) npkt[i] <= npkt[i] + 1;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic mon(int i);
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (tx[i] == 1'b0) begin
        cyc(BAUD_CYC / 2);
        for (int k = 0; k < 8; k++) begin
          cyc(BAUD_CYC);
          b[k] = tx[i];
        end
        cyc(BAUD_CYC);
        if (ncap[i] < 64) begin
          cap[i][ncap[i]] = b;
          ncap[i] = ncap[i] + 1;
        end
      end
    end
  endtask

  task automatic rx_byte(int i, logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rx[i] = f[k];
      cyc(BAUD_CYC);
    end
  endtask

  task automatic load(int i, logic [31:0] d);
    @(negedge clk);
    case (i)
      0: da = d;
      1: db = d[15:0];
      default: dc = d;
    endcase
    set[i] = 1'b1;
    @(negedge clk);
    set[i] = 1'b0;
  endtask

  // expected wire bytes for one packet
  task automatic model(int nb, bit hdr, bit cks, bit stale,
                       logic [31:0] d);
    logic [7:0] x, b;
    expq.delete();
    x = '0;
    if (hdr) expq.push_back({stale, 3'b000, 4'(nb)});
    for (int k = 0; k < nb; k++) begin
      b = d[8*k +: 8];
      expq.push_back(b);
      x = x ^ b;
    end
    if (cks) expq.push_back(x);
  endtask

  task automatic wait_cap(int i, int target, string tag);
    int t = 0;
    while (ncap[i] < target && t < 20000) begin
      cyc(1);
      t++;
    end
    chk(tag, 32'(ncap[i] >= target), 32'd1);
  endtask

  task automatic run_pkt(int i, string tag, int base, int p0);
    wait_cap(i, base + expq.size(), {tag, "_len"});
    cyc(BAUD_CYC + 4);
    for (int k = 0; k < expq.size(); k++)
      chk($sformatf("%s_b%0d", tag, k), cap[i][base+k], expq[k]);
    chk({tag, "_pkt"}, npkt[i], p0 + 1);
    chk({tag, "_idle"}, busy[i], 1'b0);
  endtask

  initial begin
    int base, p0;
    logic [31:0] d, d2;
    logic [7:0] j;
    fork
      mon(0);
      mon(1);
      mon(2);
    join_none

    cyc(3);
    chk("rst_busy", busy, 3'b000);
    chk("rst_tx", tx, 3'b111);
    chk("rst_pkt", pkt, 3'b000);
    chk("rst_stale", {sa, sb, sc}, 24'h0);
    rst_n = 1'b1;
    cyc(5);

    base = ncap[0]; p0 = npkt[0];
    load(0, 32'hA1B2C3D4);
    rx_byte(0, 8'hC6);
    model(4, 0, 0, 0, 32'hA1B2C3D4);
    run_pkt(0, "basic", base, p0);

    for (int r = 0; r < 3; r++) begin
      d = $urandom;
      j = 8'($urandom_range(0, 255));
      if (j == 8'hC6) j = 8'h3A;
      base = ncap[0]; p0 = npkt[0];
      load(0, d);
      rx_byte(0, j);
      cyc(40);
      chk("junk_quiet", ncap[0] - base, 0);
      chk("junk_busy", busy[0], 1'b0);
      rx_byte(0, 8'hC6);
      model(4, 0, 0, 0, d);
      run_pkt(0, "rnd_a", base, p0);
    end
    chk("a_stale", sa, 8'd0);

    base = ncap[1]; p0 = npkt[1];
    load(1, 32'h0F3C);
    rx_byte(1, 8'hC6);
    model(2, 1, 1, 0, 32'h0F3C);
    run_pkt(1, "hdr_ck", base, p0);
    for (int r = 0; r < 2; r++) begin
      d = {16'h0, 16'($urandom)};
      base = ncap[1]; p0 = npkt[1];
      load(1, d);
      rx_byte(1, 8'hC6);
      model(2, 1, 1, 0, d);
      run_pkt(1, "rnd_b", base, p0);
    end

    base = ncap[2]; p0 = npkt[2];
    rx_byte(2, 8'h55);
    cyc(300);
    chk("noreq_quiet", ncap[2] - base, 0);
    chk("noreq_busy", busy[2], 1'b0);
    rx_byte(2, 8'hC6);
    cyc(70);
    chk("tmo_early", busy[2], 1'b0);
    model(4, 1, 0, 1, 32'h0);
    run_pkt(2, "stale", base, p0);
    chk("stale_cnt", sc, 8'd1);

    d = $urandom; d2 = $urandom;
    base = ncap[0]; p0 = npkt[0];
    load(0, d);
    rx_byte(0, 8'hC6);
    wait_cap(0, base + 2, "mid_wait");
    load(0, d2);
    model(4, 0, 0, 0, d);
    run_pkt(0, "hold", base, p0);
    base = ncap[0]; p0 = npkt[0];
    rx_byte(0, 8'hC6);
    model(4, 0, 0, 0, d2);
    run_pkt(0, "fresh", base, p0);
    chk("fresh_stale", sa, 8'd0);

    d = $urandom;
    base = ncap[0];
    load(0, d);
    rx_byte(0, 8'hC6);
    wait_cap(0, base + 1, "rst_wait");
    cyc(BAUD_CYC * 3);
    rst_n = 1'b0;
    cyc(2);
    chk("mid_rst_busy", busy[0], 1'b0);
    chk("mid_rst_tx", tx[0], 1'b1);
    chk("mid_rst_stale", sc, 8'd0);
    rst_n = 1'b1;
    cyc(12 * BAUD_CYC);
    d = $urandom;
    base = ncap[0]; p0 = npkt[0];
    load(0, d);
    rx_byte(0, 8'hC6);
    model(4, 0, 0, 0, d);
    run_pkt(0, "post_rst", base, p0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_host_pkt.md
UART_HOST_PKT -- requirements
Module: UART_host_pkt

Interface
REQ-001 Parameter NUM_BYTES, default 4: payload bytes per packet, legal range 1..15.
REQ-002 Parameter REQ_BYTE, default 8'hC6: request byte that the host sends to ask for data.
REQ-003 Parameter HDR_EN, default 0: when 1, a header byte precedes the payload.
REQ-004 Parameter CKSUM_EN, default 0: when 1, a checksum byte follows the payload.
REQ-005 Parameter TIMEOUT_CYC, default 0: cycles a request waits for fresh data before a stale packet is sent; 0 disables the timeout.
REQ-006 clk  input  1  system clock; all state updates on rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 cntlr_data  input  8*NUM_BYTES  controller packet; byte k = cntlr_data[8k+7:8k].
REQ-009 set_cntlr_data_rdy  input  1  one-cycle pulse: cntlr_data valid this cycle.
REQ-010 RX  input  1  UART serial input.
REQ-011 TX  output  1  UART serial output.
REQ-012 busy  output  1  high while a packet is in flight (state != IDLE).
REQ-013 pkt_sent  output  1  one-cycle pulse on completion of the last byte of a packet.
REQ-014 stale_cnt  output  8  saturating count of stale packets sent.

Function
REQ-015 Shadow register captures cntlr_data on every set_cntlr_data_rdy, at any time, and sets the fresh flag; the source need not hold the data afterwards.
REQ-016 Every received byte is consumed: clr_rdy is asserted to the receiver in the cycle its rdy is seen; non-matching bytes are discarded.
REQ-017 A received byte equal to REQ_BYTE sets the req flag; a second request while req is set or busy is merged (at most one pending).
REQ-018 FSM states: IDLE, HDR, DATA, CKSUM; byte index counter 0..NUM_BYTES-1 in DATA.
REQ-019 IDLE->start when req && fresh (normal) or req && timeout expired (stale); start cycle pulses tx_trmt with the first byte, copies shadow into the send register, and clears req and fresh.
REQ-020 If set_cntlr_data_rdy coincides with start: the packet uses the pre-edge shadow, and fresh ends at 1 (set wins).
REQ-021 First state after start: HDR if HDR_EN, else DATA index 0.
REQ-022 Header byte = {stale, 3'b000, NUM_BYTES[3:0]}.
REQ-023 Payload is sent byte 0 first (LSB first); each subsequent byte is issued with a one-cycle tx_trmt pulse in the cycle tx_done is seen for the previous byte.
REQ-024 Checksum = XOR of all NUM_BYTES payload bytes (header excluded), sent after the last payload byte if CKSUM_EN.
REQ-025 After tx_done of the final byte: pkt_sent pulses, FSM returns to IDLE; a pending req may start on the next cycle.
REQ-026 Timeout counter runs only while req && !fresh && IDLE; it clears on start or reset; it expires at TIMEOUT_CYC.
REQ-027 A stale packet sends the current shadow (last data, or 0 after reset) and increments stale_cnt, saturating at 255.
REQ-028 The send register is stable for the whole packet regardless of new shadow writes.

Reset
REQ-029 Asynchronous assertion of rst_n, including mid-packet, forces IDLE; index, timeout counter, req, fresh, shadow, send register and stale_cnt all go to 0; busy=0, pkt_sent=0, TX idle high.

Structure
REQ-030 A shared package UART_host_pkg holds the state enum and the header field positions.
REQ-031 The block instantiates the existing UART_tx and UART_rx unchanged; no other sub-module.

Verification
REQ-032 Defaults, data 32'hA1B2C3D4 pulsed, then RX 8'hC6 -> TX bytes D4, C3, B2, A1; one pkt_sent pulse.
REQ-033 HDR_EN=1, CKSUM_EN=1, NUM_BYTES=2, data 16'h0F3C -> TX 02, 3C, 0F, 33.
REQ-034 RX 8'h55 then no request -> no transmission; RX 8'hC6 with no data, TIMEOUT_CYC=100, HDR_EN=1 -> after 100 cycles, header 8'h84 sent; stale_cnt=1.
REQ-035 New data pulsed mid-packet -> current packet unchanged; the next request sends the new data immediately (fresh=1).
REQ-036 rst_n low during byte 2 -> busy=0, TX high; RX 8'hC6 plus new data afterwards -> full packet from byte 0.
